y_chip: RTL and testbench
=========================

Y_CHIP -- requirements
Module: y_chip

Interface
REQ-001 Reset is synchronous and active-high; the clock is the single clock.
REQ-002 clk  input  1  clock; all state updates on the rising edge.
REQ-003 INT  input  1  synchronous active-high reset/interrupt; loads PC from entryPoint.
REQ-004 entryPoint  input  32  byte address where execution starts after INT.
REQ-005 ins  output  32  instruction word at the current PC (combinational).
REQ-006 rd2  output  32  register-file read port 2 value, i.e. x[rs2] of ins (combinational).
REQ-007 wb  output  32  value the current instruction writes back to rd (combinational).
REQ-008 Port order: ins, rd2, wb, entryPoint, INT, clk.

Function
REQ-009 Single-cycle, non-pipelined RV32 subset; one instruction commits per rising edge.
REQ-010 Unified memory of 4096 32-bit words, byte-addressed, word index = addr[13:2]; preloaded from hex file "ram.dat" at time 0; no misalignment checking.
REQ-011 ins = mem[PC[13:2]]; data port uses the same array.
REQ-012 Register file: 32 x 32-bit; two combinational read ports (rs1 = ins[19:15], rs2 = ins[24:20]); one write port (rd = ins[11:7]); x0 reads 0 and ignores writes.
REQ-013 Immediates are sign-extended: I = ins[31:20]; S = {ins[31:25], ins[11:7]}; SB = {ins[31], ins[7], ins[30:25], ins[11:8], 0}; UJ = {ins[31], ins[19:12], ins[20], ins[30:21], 0}.
REQ-014 Supported instructions and wb values:
- opcode 0x33: add (f3 0, f7 0x00), sub (f3 0, f7 0x20), and (f3 7), or (f3 6), slt (f3 2, signed, result 1 or 0); wb = ALU result.
- opcode 0x13 f3 0: addi; wb = x[rs1] + I.
- opcode 0x03 f3 2: lw; wb = mem[(x[rs1] + I)[13:2]].
- opcode 0x23 f3 2: sw; wb = effective address x[rs1] + S; no register write.
- opcode 0x63 f3 0: beq; wb = x[rs1] - x[rs2]; no register write.
- opcode 0x6F: jal; wb = PC + 4.
- opcode 0x67 f3 0: jalr; wb = PC + 4.
REQ-015 Any other encoding is a NOP: wb = 0, no register or memory write, PC + 4.
REQ-016 Next PC: jal = PC + UJ; jalr = (x[rs1] + I) & ~1; beq taken (x[rs1] == x[rs2]) = PC + SB; otherwise PC + 4. All arithmetic is 32-bit with wrap-around.
REQ-017 On a rising edge with INT = 0: register write of wb to rd (if the instruction writes), memory write of x[rs2] (sw), PC <= next PC, all at the same edge.
REQ-018 Within one instruction, register reads see pre-edge values; writing rd == rs1/rs2 takes effect for the next instruction only.
REQ-019 Outputs settle combinationally after each edge; they are sampled while clk is low.

Reset
REQ-020 Rising edge with INT = 1: PC <= entryPoint; x1..x31 <= 0; no memory write; the in-flight instruction does not commit.
REQ-021 After the INT edge: ins = mem[entryPoint[13:2]]; rd2 = 0; wb is per REQ-014 with zeroed registers.
REQ-022 INT asserted mid-program takes priority over any branch, jump, or write on that edge.
REQ-023 Before the first INT edge, PC and outputs are undefined.

Verification
REQ-024 Load entryPoint = 128 with INT = 1 at one edge -> ins = mem[32].
REQ-025 At 128 "addi x5,x0,7" (0x00700293), then "add x6,x5,x5" -> first wb = 7; next wb = 14, rd2 = 7.
REQ-026 "sw x6,0(x0)" then "lw x7,0(x0)" -> sw wb = 0, rd2 = 14; lw wb = 14; x7 = 14 after the edge.
REQ-027 "beq x5,x5,-8" at PC 140 -> next ins is fetched from 132; with x5 != x6 the next PC is 144.
REQ-028 "jal x1,8" at PC 128 -> wb = 132, next PC 136; "jalr x0,0(x1)" -> next PC 132, no write.
REQ-029 "sub" giving a negative result followed by "slt" -> wb = 0xFFFFFFFF style two's-complement result and slt = 1; an unsupported opcode -> wb = 0, PC + 4; writes to x0 keep x0 = 0.

Source files
------------

// File: rtl/y_chip.sv
// Single-cycle RV32 subset core; instruction fetch and data access share one 4096-word memory.
// Latency: one instruction commits per rising clk edge, outputs are combinational; no handshake, never stalls.
module y_chip (
    output logic [31:0] ins,
    output logic [31:0] rd2,
    output logic [31:0] wb,
    input  logic [31:0] entryPoint,
    input  logic        INT,
    input  logic        clk
);
    localparam logic [6:0] OP_R      = 7'h33;
    localparam logic [6:0] OP_IMM    = 7'h13;
    localparam logic [6:0] OP_LOAD   = 7'h03;
    localparam logic [6:0] OP_STORE  = 7'h23;
    localparam logic [6:0] OP_BRANCH = 7'h63;
    localparam logic [6:0] OP_JAL    = 7'h6F;
    localparam logic [6:0] OP_JALR   = 7'h67;

    // Memory is never reset; its program image (ram.dat) is placed by the environment before the first INT.
    logic [31:0] mem_q [0:4095];
    logic [31:0] rf_q  [0:31];
    logic [31:0] pc_q, pc_d;

    logic [6:0]  opcode, funct7;
    logic [2:0]  funct3;
    logic [4:0]  rs1, rs2, rd;
    logic [31:0] rs1_val, imm_i, imm_s, imm_b, imm_j;
    logic [31:0] ea, load_val, pc_plus4;
    logic        rf_we, mem_we;

    assign ins    = mem_q[pc_q[13:2]];
    assign opcode = ins[6:0];
    assign rd     = ins[11:7];
    assign funct3 = ins[14:12];
    assign rs1    = ins[19:15];
    assign rs2    = ins[24:20];
    assign funct7 = ins[31:25];

    assign rs1_val = (rs1 == 5'd0) ? 32'd0 : rf_q[rs1];
    assign rd2     = (rs2 == 5'd0) ? 32'd0 : rf_q[rs2];

    assign imm_i = {{20{ins[31]}}, ins[31:20]};
    assign imm_s = {{20{ins[31]}}, ins[31:25], ins[11:7]};
    assign imm_b = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
    assign imm_j = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};

    // One adder serves load/store addressing and the jalr target.
    assign ea       = rs1_val + ((opcode == OP_STORE) ? imm_s : imm_i);
    assign load_val = mem_q[ea[13:2]];
    assign pc_plus4 = pc_q + 32'd4;

    always_comb begin
        wb     = 32'd0;
        rf_we  = 1'b0;
        mem_we = 1'b0;
        pc_d   = pc_plus4;
        case (opcode)
            OP_R: begin
                rf_we = 1'b1;
                case (funct3)
                    3'd0: begin
                        if (funct7 == 7'h00)      wb = rs1_val + rd2;
                        else if (funct7 == 7'h20) wb = rs1_val - rd2;
                        else                      rf_we = 1'b0;
                    end
                    3'd7:    wb = rs1_val & rd2;
                    3'd6:    wb = rs1_val | rd2;
                    3'd2:    wb = {31'd0, ($signed(rs1_val) < $signed(rd2))};
                    default: rf_we = 1'b0;
                endcase
            end
            OP_IMM: if (funct3 == 3'd0) begin
                wb    = rs1_val + imm_i;
                rf_we = 1'b1;
            end
            OP_LOAD: if (funct3 == 3'd2) begin
                wb    = load_val;
                rf_we = 1'b1;
            end
            OP_STORE: if (funct3 == 3'd2) begin
                wb     = ea;
                mem_we = 1'b1;
            end
            OP_BRANCH: if (funct3 == 3'd0) begin
                wb = rs1_val - rd2;
                if (rs1_val == rd2) pc_d = pc_q + imm_b;
            end
            OP_JAL: begin
                wb    = pc_plus4;
                rf_we = 1'b1;
                pc_d  = pc_q + imm_j;
            end
            OP_JALR: if (funct3 == 3'd0) begin
                wb    = pc_plus4;
                rf_we = 1'b1;
                pc_d  = {ea[31:1], 1'b0};
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (INT) pc_q <= entryPoint;
        else     pc_q <= pc_d;
    end

    always_ff @(posedge clk) begin
        if (INT) begin
            for (int i = 0; i < 32; i++) rf_q[i] <= 32'd0;
        end else if (rf_we && (rd != 5'd0)) begin
            rf_q[rd] <= wb;
        end
    end

    always_ff @(posedge clk) begin
        if (!INT && mem_we) mem_q[ea[13:2]] <= rd2;
    end
endmodule

// File: tb/tb_y_chip.sv
// Bench for y_chip: directed programs plus random instruction streams compared each cycle
// against an instruction-level reference model of the architectural state.
module tb_y_chip;
    logic        clk;
    logic [31:0] ins, rd2, wb, entryPoint;
    logic        INT;

    y_chip dut (
        .ins       (ins),
        .rd2       (rd2),
        .wb        (wb),
        .entryPoint(entryPoint),
        .INT       (INT),
        .clk       (clk)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] m_mem [4096];
    logic [31:0] m_x   [32];
    logic [31:0] m_pc;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    // ---------------- encoders ----------------
    function automatic logic [31:0] enc_r(input logic [31:0] f7, input logic [31:0] r2,
                                          input logic [31:0] r1, input logic [31:0] f3,
                                          input logic [31:0] rdn, input logic [31:0] op);
        return {f7[6:0], r2[4:0], r1[4:0], f3[2:0], rdn[4:0], op[6:0]};
    endfunction
    function automatic logic [31:0] enc_i(input logic [31:0] imm, input logic [31:0] r1,
                                          input logic [31:0] f3, input logic [31:0] rdn,
                                          input logic [31:0] op);
        return {imm[11:0], r1[4:0], f3[2:0], rdn[4:0], op[6:0]};
    endfunction
    function automatic logic [31:0] enc_s(input logic [31:0] imm, input logic [31:0] r2,
                                          input logic [31:0] r1);
        return {imm[11:5], r2[4:0], r1[4:0], 3'd2, imm[4:0], 7'h23};
    endfunction
    function automatic logic [31:0] enc_b(input logic [31:0] imm, input logic [31:0] r2,
                                          input logic [31:0] r1);
        return {imm[12], imm[10:5], r2[4:0], r1[4:0], 3'd0, imm[4:1], imm[11], 7'h63};
    endfunction
    function automatic logic [31:0] enc_j(input logic [31:0] imm, input logic [31:0] rdn);
        return {imm[20], imm[10:1], imm[11], imm[19:12], rdn[4:0], 7'h6F};
    endfunction

    // ---------------- reference model ----------------
    function automatic logic [31:0] sx(input logic [31:0] v, input int bits);
        int t;
        t = v << (32 - bits);
        return t >>> (32 - bits);
    endfunction

    task automatic model_reset(input logic [31:0] ep);
        m_pc = ep;
        for (int i = 0; i < 32; i++) m_x[i] = 32'd0;
    endtask

    task automatic model_eval(output logic [31:0] e_ins, output logic [31:0] e_rd2,
                              output logic [31:0] e_wb, output logic [31:0] e_npc,
                              output bit wr_rd, output bit wr_mem, output logic [31:0] e_addr);
        logic [31:0] i, a, b, imm_i, imm_s, imm_b, imm_j;
        int op, f3, f7;
        i  = m_mem[m_pc[13:2]];
        op = int'(i & 32'd127);
        f3 = int'((i >> 12) & 32'd7);
        f7 = int'((i >> 25) & 32'd127);
        a  = m_x[(i >> 15) & 32'd31];
        b  = m_x[(i >> 20) & 32'd31];
        imm_i = sx(i >> 20, 12);
        imm_s = sx(((i >> 25) << 5) | ((i >> 7) & 32'd31), 12);
        imm_b = sx((((i >> 31) & 1) << 12) | (((i >> 7) & 1) << 11) |
                   (((i >> 25) & 63) << 5) | (((i >> 8) & 15) << 1), 13);
        imm_j = sx((((i >> 31) & 1) << 20) | (((i >> 12) & 255) << 12) |
                   (((i >> 20) & 1) << 11) | (((i >> 21) & 1023) << 1), 21);
        e_ins = i; e_rd2 = b; e_wb = 32'd0; e_npc = m_pc + 32'd4;
        wr_rd = 1'b0; wr_mem = 1'b0; e_addr = 32'd0;
        if (op == 'h33 && f3 == 0 && f7 == 0)         begin e_wb = a + b; wr_rd = 1; end
        else if (op == 'h33 && f3 == 0 && f7 == 'h20) begin e_wb = a - b; wr_rd = 1; end
        else if (op == 'h33 && f3 == 7)               begin e_wb = a & b; wr_rd = 1; end
        else if (op == 'h33 && f3 == 6)               begin e_wb = a | b; wr_rd = 1; end
        else if (op == 'h33 && f3 == 2) begin
            e_wb = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0; wr_rd = 1;
        end
        else if (op == 'h13 && f3 == 0) begin e_wb = a + imm_i; wr_rd = 1; end
        else if (op == 'h03 && f3 == 2) begin
            e_addr = a + imm_i; e_wb = m_mem[e_addr[13:2]]; wr_rd = 1;
        end
        else if (op == 'h23 && f3 == 2) begin e_addr = a + imm_s; e_wb = e_addr; wr_mem = 1; end
        else if (op == 'h63 && f3 == 0) begin
            e_wb = a - b;
            if (a == b) e_npc = m_pc + imm_b;
        end
        else if (op == 'h6F) begin e_wb = m_pc + 4; wr_rd = 1; e_npc = m_pc + imm_j; end
        else if (op == 'h67 && f3 == 0) begin
            e_wb = m_pc + 4; wr_rd = 1; e_npc = (a + imm_i) & 32'hFFFF_FFFE;
        end
    endtask

    // Compare outputs against the model, then apply one rising edge (with INT = irq).
    task automatic step(input bit irq, input logic [31:0] ep);
        logic [31:0] e_ins, e_rd2, e_wb, e_npc, e_addr;
        bit wr_rd, wr_mem;
        int rdn;
        model_eval(e_ins, e_rd2, e_wb, e_npc, wr_rd, wr_mem, e_addr);
        check($sformatf("ins@%08h", m_pc), ins, e_ins);
        check($sformatf("rd2@%08h", m_pc), rd2, e_rd2);
        check($sformatf("wb@%08h", m_pc), wb, e_wb);
        INT = irq;
        entryPoint = ep;
        if (irq) model_reset(ep);
        else begin
            rdn = int'((e_ins >> 7) & 32'd31);
            if (wr_rd && rdn != 0) m_x[rdn] = e_wb;
            if (wr_mem) m_mem[e_addr[13:2]] = e_rd2;
            m_pc = e_npc;
        end
        @(negedge clk);
        #1;
        INT = 1'b0;
    endtask

    task automatic clear_image();
        for (int i = 0; i < 4096; i++) m_mem[i] = 32'd0;
    endtask

    task automatic put(input logic [31:0] addr, input logic [31:0] word);
        m_mem[addr[13:2]] = word;
    endtask

    task automatic load_and_reset(input logic [31:0] ep);
        INT = 1'b1;
        entryPoint = ep;
        for (int i = 0; i < 4096; i++) dut.mem_q[i] = m_mem[i];
        @(negedge clk);
        #1;
        INT = 1'b0;
        model_reset(ep);
    endtask

    function automatic logic [31:0] rand_instr();
        int k, sel;
        logic [31:0] r1, r2, rdn;
        k   = int'($urandom_range(0, 9));
        r1  = $urandom_range(0, 7);
        r2  = $urandom_range(0, 7);
        rdn = $urandom_range(0, 7);
        case (k)
            0, 9: begin
                sel = int'($urandom_range(0, 4));
                case (sel)
                    0:       return enc_r(0, r2, r1, 0, rdn, 'h33);
                    1:       return enc_r('h20, r2, r1, 0, rdn, 'h33);
                    2:       return enc_r(0, r2, r1, 7, rdn, 'h33);
                    3:       return enc_r(0, r2, r1, 6, rdn, 'h33);
                    default: return enc_r(0, r2, r1, 2, rdn, 'h33);
                endcase
            end
            1, 2:    return enc_i($urandom, r1, 0, rdn, 'h13);
            3:       return enc_i($urandom, r1, 2, rdn, 'h03);
            4:       return enc_s($urandom, r2, r1);
            5:       return enc_b(2 * $urandom_range(0, 63) - 64, r2, r1);
            6:       return enc_j(4 * $urandom_range(0, 31) - 64, rdn);
            7:       return enc_i($urandom_range(0, 255), r1, 0, rdn, 'h67);
            default: return $urandom;
        endcase
    endfunction

    initial begin
        logic [31:0] w_nop_next, w_jalr, w_j12, w_beq, w_mark, w_jal;
        INT = 1'b0;
        entryPoint = 32'd0;

        // ---- ALU / load-store program ----
        clear_image();
        put(128, 32'h0070_0293);                   // addi x5,x0,7
        put(132, enc_r(0, 5, 5, 0, 6, 'h33));      // add  x6,x5,x5
        put(136, enc_s(0, 6, 0));                  // sw   x6,0(x0)
        put(140, enc_i(0, 0, 2, 7, 'h03));         // lw   x7,0(x0)
        put(144, enc_r(0, 7, 0, 0, 8, 'h33));      // add  x8,x0,x7
        put(148, enc_r('h20, 5, 0, 0, 9, 'h33));   // sub  x9,x0,x5
        put(152, enc_r(0, 5, 9, 2, 10, 'h33));     // slt  x10,x9,x5
        put(156, enc_i(3, 5, 0, 0, 'h13));         // addi x0,x5,3
        put(160, enc_r(0, 0, 5, 7, 11, 'h33));     // and  x11,x5,x0
        put(164, 32'hFFFF_FFFF);                   // unsupported
        w_nop_next = enc_r(0, 6, 5, 6, 12, 'h33);  // or   x12,x5,x6
        put(168, w_nop_next);
        load_and_reset(32'd128);
        check("int_ins", ins, 32'h0070_0293);
        check("int_rd2", rd2, 32'd0);
        check("addi_wb", wb, 32'd7);
        step(0, 0);
        check("add_wb", wb, 32'd14);
        check("add_rd2", rd2, 32'd7);
        step(0, 0);
        check("sw_wb", wb, 32'd0);
        check("sw_rd2", rd2, 32'd14);
        step(0, 0);
        check("lw_wb", wb, 32'd14);
        step(0, 0);
        check("x7_after_lw", rd2, 32'd14);
        step(0, 0);
        check("sub_wb", wb, 32'hFFFF_FFF9);
        step(0, 0);
        check("slt_wb", wb, 32'd1);
        step(0, 0);
        check("addi_x0_wb", wb, 32'd10);
        step(0, 0);
        check("x0_stays_zero", rd2, 32'd0);
        step(0, 0);
        check("nop_wb", wb, 32'd0);
        step(0, 0);
        check("nop_pc4_ins", ins, w_nop_next);
        check("or_wb", wb, 32'd15);
        step(0, 0);

        // ---- jump / branch program ----
        clear_image();
        w_jal  = enc_j(8, 1);
        w_j12  = enc_j(12, 0);
        w_jalr = enc_i(0, 1, 0, 0, 'h67);
        w_beq  = enc_b(-8, 5, 5);
        put(128, w_jal);                           // jal  x1,8
        put(132, w_j12);                           // jal  x0,12
        put(136, w_jalr);                          // jalr x0,0(x1)
        put(140, w_beq);                           // beq  x5,x5,-8
        put(144, enc_i(1, 0, 0, 6, 'h13));         // addi x6,x0,1
        put(148, enc_j(-8, 0));                    // jal  x0,-8
        load_and_reset(32'd128);
        check("jal_wb", wb, 32'd132);
        step(0, 0);
        check("jal_target", ins, w_jalr);
        check("jalr_wb", wb, 32'd140);
        step(0, 0);
        check("jalr_target", ins, w_j12);
        step(0, 0);
        step(0, 0);
        step(0, 0);
        check("beq_fetch", ins, w_beq);
        check("beq_eq_wb", wb, 32'd0);
        step(0, 0);
        check("beq_taken", ins, w_j12);
        step(1, 32'd128);                          // INT overrides the jump at this edge
        check("int_over_jump", ins, w_jal);
        check("int_rd2_zero", rd2, 32'd0);
        step(0, 0);

        // ---- branch not taken ----
        clear_image();
        w_mark = enc_i('h123, 0, 0, 7, 'h13);
        put(128, enc_i(1, 0, 0, 6, 'h13));         // addi x6,x0,1
        put(140, enc_b(-8, 6, 5));                 // beq  x5,x6,-8
        put(144, w_mark);
        load_and_reset(32'd128);
        step(0, 0);
        step(0, 0);
        step(0, 0);
        check("beq_ne_wb", wb, 32'hFFFF_FFFF);
        step(0, 0);
        check("beq_not_taken", ins, w_mark);
        check("marker_wb", wb, 32'h123);
        step(0, 0);

        // ---- random programs with occasional INT ----
        for (int i = 0; i < 4096; i++) m_mem[i] = rand_instr();
        load_and_reset($urandom);
        for (int c = 0; c < 3000; c++) begin
            step($urandom_range(0, 99) == 0, $urandom);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, got no end expected end");
        $fatal(1, "watchdog");
    end
endmodule
